pipe_unpal: RTL and testbench

PIPE_UNPAL -- requirements
Module: pipe_unpal

---
 rtl/pipe_pkg.sv | 18 +
 rtl/pipe_unpal_if.sv | 25 ++
 rtl/pipe_unpal.sv | 95 +++++++++
 tb/tb_pipe_unpal.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared FSM encoding and constant helpers for the word-to-beat unpacker
package pipe_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_unpal_if.sv
// rtl/pipe_unpal_if.sv - word-in / beat-out handshake bundle for pipe_unpal
interface pipe_unpal_if #(
  parameter int W_DATA = 32,
  parameter int W_BEAT = 8
);
  logic              i_valid;
  logic              o_ready;
  logic [W_DATA-1:0] i_data;
  logic              i_last;
  logic              o_valid;
  logic              i_ready;
  logic [W_BEAT-1:0] o_data;
  logic              o_last;
  logic [15:0]       o_words;

  modport master (
    output i_valid, i_data, i_last, i_ready,
    input  o_ready, o_valid, o_data, o_last, o_words
  );

  modport slave (
    input  i_valid, i_data, i_last, i_ready,
    output o_ready, o_valid, o_data, o_last, o_words
  );
endinterface

// File: rtl/pipe_unpal.sv
// rtl/pipe_unpal.sv - splits W_DATA words into W_BEAT beats, LSB beat first
module pipe_unpal
  import pipe_pkg::*;
#(
  parameter int W_DATA = 32,
  parameter int W_BEAT = 8
) (
  input logic          i_clk,
  input logic          i_rst,
  pipe_unpal_if.slave  bus
);

  localparam int N_BEATS = W_DATA / W_BEAT;
  localparam int W_CNT   = (clog2(N_BEATS) < 1) ? 1 : clog2(N_BEATS);

  state_t                              state, state_nx;
  logic [W_DATA-1:0]                   shreg;
  logic [N_BEATS-1:0][W_BEAT-1:0]      beats;
  logic [W_CNT-1:0]                    idx;
  logic                                last_q;
  logic [15:0]                         words;
  logic                                live;
  logic                                last_idx;
  logic                                beat_acc;
  logic                                word_acc;

  assign beats    = shreg;
  assign last_idx = (idx == W_CNT'(N_BEATS - 1));
  assign beat_acc = (state == SHIFT) && bus.i_ready;
  assign word_acc = bus.i_valid && bus.o_ready;

  // live keeps o_ready low through reset without a combinational path from i_rst
  always_comb begin
    state_nx    = state;
    bus.o_ready = 1'b0;
    bus.o_valid = 1'b0;
    bus.o_data  = '0;
    bus.o_last  = 1'b0;
    case (state)
      IDLE: begin
        bus.o_ready = live;
        if (word_acc) state_nx = SHIFT;
      end
      SHIFT: begin
        bus.o_ready = live && last_idx && bus.i_ready;
        bus.o_valid = 1'b1;
        bus.o_data  = beats[idx];
        bus.o_last  = last_idx && last_q;
        if (beat_acc && last_idx) state_nx = word_acc ? SHIFT : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.o_words = words;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      live  <= 1'b0;
    end else begin
      state <= state_nx;
      live  <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      shreg  <= '0;
      last_q <= 1'b0;
    end else if (word_acc) begin
      shreg  <= bus.i_data;
      last_q <= bus.i_last;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      idx <= '0;
    end else if (word_acc) begin
      idx <= '0;
    end else if (beat_acc && !last_idx) begin
      idx <= idx + W_CNT'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      words <= '0;
    end else if (beat_acc && last_idx) begin
      words <= words + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_unpal.sv
// tb/tb_pipe_unpal.sv - table-driven and scoreboard bench for pipe_unpal
module tb_pipe_unpal;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       fin;
  } beat_t;

  typedef struct {
    logic [31:0]     data;
    logic            last;
    logic [7:0]      stall;
    logic [3:0][7:0] beats;
    logic [15:0]     words;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   beat_cnt;
  beat_t exp_q[$];
  vec_t  tbl[5];
  vec_t  v1;

  pipe_unpal_if #(.W_DATA(32), .W_BEAT(8))  bus0 ();
  pipe_unpal_if #(.W_DATA(16), .W_BEAT(8))  bus16 ();
  pipe_unpal_if #(.W_DATA(64), .W_BEAT(16)) bus64 ();

  pipe_unpal #(.W_DATA(32), .W_BEAT(8))  dut   (.i_clk(clk), .i_rst(rst), .bus(bus0));
  pipe_unpal #(.W_DATA(16), .W_BEAT(8))  dut16 (.i_clk(clk), .i_rst(rst), .bus(bus16));
  pipe_unpal #(.W_DATA(64), .W_BEAT(16)) dut64 (.i_clk(clk), .i_rst(rst), .bus(bus64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every presented beat must match the queue head; a stalled head is re-checked next cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (bus0.o_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {55'd0, bus0.o_data, 1'b1}, 64'd0);
        end else begin
          chk("beat_data", bus0.o_data, exp_q[0].data);
          chk("beat_last", bus0.o_last, exp_q[0].last);
          chk("beat_ready", bus0.o_ready, exp_q[0].fin && bus0.i_ready);
          if (bus0.i_ready) begin
            void'(exp_q.pop_front());
            beat_cnt++;
          end
        end
      end else begin
        chk("idle_data", bus0.o_data, 8'h00);
        chk("idle_last", bus0.o_last, 1'b0);
      end
    end
  end

  task automatic run_vec(input vec_t v, input string nm);
    int start, k, ek, n, cyc;
    for (int b = 0; b < 4; b++)
      exp_q.push_back('{data: v.beats[b], last: v.last && (b == 3), fin: (b == 3)});
    start = beat_cnt;
    bus0.i_valid = 1'b1;
    bus0.i_data  = v.data;
    bus0.i_last  = v.last;
    bus0.i_ready = 1'b0;
    cyc = 0;
    @(negedge clk);
    while (!bus0.o_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, "_accept"}, bus0.o_ready, 1'b1);
    @(posedge clk); #1;
    bus0.i_valid = 1'b0;
    ek = 0;
    n  = 0;
    for (int j = 0; j < 32 && ek == 0; j++) begin
      if (!v.stall[j % 8]) begin
        n++;
        if (n == 4) ek = j + 1;
      end
    end
    k = 0;
    while (beat_cnt - start < 4 && k < 40) begin
      bus0.i_ready = !v.stall[k % 8];
      @(posedge clk); #1;
      k++;
    end
    bus0.i_ready = 1'b0;
    chk({nm, "_beats"}, beat_cnt - start, 4);
    chk({nm, "_cycles"}, k, ek);
    chk({nm, "_words"}, bus0.o_words, v.words);
  endtask

  logic [31:0] sw [3];
  logic [7:0]  e16 [2];
  logic [15:0] e64 [4];
  int          start, cyc, wi;
  logic        acc;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0; beat_cnt = 0;
    tbl[0] = '{32'hA1B2C3D4, 1'b1, 8'b0000_0000, {8'hA1, 8'hB2, 8'hC3, 8'hD4}, 16'd1};
    tbl[1] = '{32'h0F1E2D3C, 1'b0, 8'b0000_0110, {8'h0F, 8'h1E, 8'h2D, 8'h3C}, 16'd2};
    tbl[2] = '{32'hDEADBEEF, 1'b1, 8'b0101_0101, {8'hDE, 8'hAD, 8'hBE, 8'hEF}, 16'd3};
    tbl[3] = '{32'h00000000, 1'b0, 8'b0000_0000, {8'h00, 8'h00, 8'h00, 8'h00}, 16'd4};
    tbl[4] = '{32'hFFFFFFFF, 1'b1, 8'b0010_1000, {8'hFF, 8'hFF, 8'hFF, 8'hFF}, 16'd5};
    sw[0] = 32'h03020100; sw[1] = 32'h07060504; sw[2] = 32'h0B0A0908;
    e16[0] = 8'hEF; e16[1] = 8'hBE;
    e64[0] = 16'hCDEF; e64[1] = 16'h89AB; e64[2] = 16'h4567; e64[3] = 16'h0123;

    rst = 1'b1;
    bus0.i_valid = 0; bus0.i_data = '0; bus0.i_last = 0; bus0.i_ready = 0;
    bus16.i_valid = 0; bus16.i_data = '0; bus16.i_last = 0; bus16.i_ready = 0;
    bus64.i_valid = 0; bus64.i_data = '0; bus64.i_last = 0; bus64.i_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", bus0.o_ready, 1'b0);
    chk("rst_valid", bus0.o_valid, 1'b0);
    chk("rst_data", bus0.o_data, 8'h00);
    chk("rst_last", bus0.o_last, 1'b0);
    chk("rst_words", bus0.o_words, 16'h0000);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", bus0.o_ready, 1'b1);

    for (int i = 0; i < 5; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Three words back to back: one accept cycle then twelve beats with no gap
    for (int w = 0; w < 3; w++)
      for (int b = 0; b < 4; b++)
        exp_q.push_back('{data: sw[w][b*8 +: 8], last: (w == 2) && (b == 3), fin: (b == 3)});
    start = beat_cnt; cyc = 0; wi = 0;
    bus0.i_valid = 1'b1; bus0.i_data = sw[0]; bus0.i_last = 1'b0; bus0.i_ready = 1'b1;
    while (beat_cnt - start < 12 && cyc < 60) begin
      @(negedge clk);
      acc = bus0.o_ready && bus0.i_valid;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        wi++;
        if (wi < 3) begin
          bus0.i_data = sw[wi];
          bus0.i_last = (wi == 2);
        end else begin
          bus0.i_valid = 1'b0;
        end
      end
    end
    bus0.i_valid = 1'b0; bus0.i_ready = 1'b0;
    chk("stream_beats", beat_cnt - start, 12);
    chk("stream_cycles", cyc, 13);
    chk("stream_accepts", wi, 3);
    chk("stream_words", bus0.o_words, 16'd8);

    // Reset while the third beat of 0x11223344 is on the output
    for (int b = 0; b < 4; b++)
      exp_q.push_back('{data: 8'h44 - 8'(b * 8'h11), last: 1'b0, fin: (b == 3)});
    bus0.i_valid = 1'b1; bus0.i_data = 32'h11223344; bus0.i_last = 1'b0; bus0.i_ready = 1'b1;
    @(posedge clk); #1;
    bus0.i_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus0.i_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_valid", bus0.o_valid, 1'b0);
    chk("midrst_words", bus0.o_words, 16'd0);
    chk("midrst_ready", bus0.o_ready, 1'b0);
    chk("midrst_pending", exp_q.size(), 2);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_ready_after", bus0.o_ready, 1'b1);
    chk("midrst_idle_valid", bus0.o_valid, 1'b0);
    v1 = '{32'h55667788, 1'b1, 8'b0000_0000, {8'h55, 8'h66, 8'h77, 8'h88}, 16'd1};
    run_vec(v1, "post_rst");

    force dut.words = 16'hFFFF;
    #1;
    release dut.words;
    #1;
    chk("wrap_preload", bus0.o_words, 16'hFFFF);
    v1 = '{32'h13579BDF, 1'b0, 8'b0000_0010, {8'h13, 8'h57, 8'h9B, 8'hDF}, 16'h0000};
    run_vec(v1, "wrap");

    bus16.i_valid = 1'b1; bus16.i_data = 16'hBEEF; bus16.i_last = 1'b1; bus16.i_ready = 1'b1;
    @(negedge clk);
    chk("w16_accept", bus16.o_ready, 1'b1);
    @(posedge clk); #1;
    bus16.i_valid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      chk($sformatf("w16_valid%0d", b), bus16.o_valid, 1'b1);
      chk($sformatf("w16_data%0d", b), bus16.o_data, e16[b]);
      chk($sformatf("w16_last%0d", b), bus16.o_last, b == 1);
      @(posedge clk); #1;
    end
    chk("w16_words", bus16.o_words, 16'd1);
    chk("w16_idle", bus16.o_valid, 1'b0);

    bus64.i_valid = 1'b1; bus64.i_data = 64'h0123456789ABCDEF; bus64.i_last = 1'b1; bus64.i_ready = 1'b1;
    @(negedge clk);
    chk("w64_accept", bus64.o_ready, 1'b1);
    @(posedge clk); #1;
    bus64.i_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      chk($sformatf("w64_valid%0d", b), bus64.o_valid, 1'b1);
      chk($sformatf("w64_data%0d", b), bus64.o_data, e64[b]);
      chk($sformatf("w64_last%0d", b), bus64.o_last, b == 3);
      @(posedge clk); #1;
    end
    chk("w64_words", bus64.o_words, 16'd1);
    chk("w64_idle", bus64.o_valid, 1'b0);

    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
